// File: rtl/mc_cu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_cu_pkg                                                            |
// | Shared encodings for the multi-cycle MIPS-subset control unit.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mc_cu_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [3:0] C_ALU_ADD = 4'b0000;
  localparam logic [3:0] C_ALU_SUB = 4'b0100;
  localparam logic [3:0] C_ALU_AND = 4'b0001;
  localparam logic [3:0] C_ALU_OR  = 4'b0101;
  localparam logic [3:0] C_ALU_XOR = 4'b0010;
  localparam logic [3:0] C_ALU_LUI = 4'b0110;
  localparam logic [3:0] C_ALU_SLL = 4'b0011;
  localparam logic [3:0] C_ALU_SRL = 4'b0111;
  localparam logic [3:0] C_ALU_SRA = 4'b1111;

  localparam logic [1:0] C_PC_ALU    = 2'b00;
  localparam logic [1:0] C_PC_ALUOUT = 2'b01;
  localparam logic [1:0] C_PC_REGA   = 2'b10;
  localparam logic [1:0] C_PC_JUMP   = 2'b11;

  localparam logic [1:0] C_SRCB_REGB  = 2'b00;
  localparam logic [1:0] C_SRCB_FOUR  = 2'b01;
  localparam logic [1:0] C_SRCB_IMM   = 2'b10;
  localparam logic [1:0] C_SRCB_IMMSH = 2'b11;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_ANDI  = 6'b001100;
  localparam logic [5:0] C_OP_ORI   = 6'b001101;
  localparam logic [5:0] C_OP_XORI  = 6'b001110;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_LUI   = 6'b001111;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_JAL   = 6'b000011;

  localparam logic [5:0] C_FN_ADD = 6'b100000;
  localparam logic [5:0] C_FN_SUB = 6'b100010;
  localparam logic [5:0] C_FN_AND = 6'b100100;
  localparam logic [5:0] C_FN_OR  = 6'b100101;
  localparam logic [5:0] C_FN_XOR = 6'b100110;
  localparam logic [5:0] C_FN_SLL = 6'b000000;
  localparam logic [5:0] C_FN_SRL = 6'b000010;
  localparam logic [5:0] C_FN_SRA = 6'b000011;
  localparam logic [5:0] C_FN_JR  = 6'b001000;

  typedef struct packed {
    logic i_add;
    logic i_sub;
    logic i_and;
    logic i_or;
    logic i_xor;
    logic i_sll;
    logic i_srl;
    logic i_sra;
    logic i_jr;
    logic i_addi;
    logic i_andi;
    logic i_ori;
    logic i_xori;
    logic i_lw;
    logic i_sw;
    logic i_beq;
    logic i_bne;
    logic i_lui;
    logic i_j;
    logic i_jal;
  } instr_t;

  // Branches compare by subtraction; loads/stores compute addresses with add.
  function automatic logic [3:0] alu_op(input instr_t d);
    logic [3:0] r;
    r = C_ALU_ADD;
    if (d.i_sub | d.i_beq | d.i_bne)  r = C_ALU_SUB;
    else if (d.i_and | d.i_andi)      r = C_ALU_AND;
    else if (d.i_or | d.i_ori)        r = C_ALU_OR;
    else if (d.i_xor | d.i_xori)      r = C_ALU_XOR;
    else if (d.i_lui)                 r = C_ALU_LUI;
    else if (d.i_sll)                 r = C_ALU_SLL;
    else if (d.i_srl)                 r = C_ALU_SRL;
    else if (d.i_sra)                 r = C_ALU_SRA;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_cu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_cu_if                                                             |
// | Control bundle between the control unit and the shared datapath.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mc_cu_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       wmem;
  logic       wir;
  logic       wpc;
  logic       wreg;
  logic       regrt;
  logic       m2reg;
  logic       jal;
  logic [3:0] aluc;
  logic       shift;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       sext;
  logic [1:0] pcsource;
  logic [2:0] state;

  modport master (
    input  op, func, z, mem_ready,
    output mem_req, iord, wmem, wir, wpc, wreg, regrt, m2reg, jal,
           aluc, shift, alusrca, alusrcb, sext, pcsource, state
  );

  modport slave (
    output op, func, z, mem_ready,
    input  mem_req, iord, wmem, wir, wpc, wreg, regrt, m2reg, jal,
           aluc, shift, alusrca, alusrcb, sext, pcsource, state
  );
endinterface
`default_nettype wire

// File: rtl/mc_cu_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_cu_decode                                                         |
// | Combinational op/func decoder producing one-hot instruction flags.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mc_cu_decode
  import mc_cu_pkg::*;
(
  input  wire logic [5:0] i_op,
  input  wire logic [5:0] i_func,
  output instr_t          o_dec,
  output logic            o_illegal
);

  always_comb begin
    o_dec     = '0;
    o_illegal = 1'b0;
    case (i_op)
      C_OP_RTYPE: begin
        case (i_func)
          C_FN_ADD: o_dec.i_add = 1'b1;
          C_FN_SUB: o_dec.i_sub = 1'b1;
          C_FN_AND: o_dec.i_and = 1'b1;
          C_FN_OR:  o_dec.i_or  = 1'b1;
          C_FN_XOR: o_dec.i_xor = 1'b1;
          C_FN_SLL: o_dec.i_sll = 1'b1;
          C_FN_SRL: o_dec.i_srl = 1'b1;
          C_FN_SRA: o_dec.i_sra = 1'b1;
          C_FN_JR:  o_dec.i_jr  = 1'b1;
          default:  o_illegal   = 1'b1;
        endcase
      end
      C_OP_ADDI: o_dec.i_addi = 1'b1;
      C_OP_ANDI: o_dec.i_andi = 1'b1;
      C_OP_ORI:  o_dec.i_ori  = 1'b1;
      C_OP_XORI: o_dec.i_xori = 1'b1;
      C_OP_LW:   o_dec.i_lw   = 1'b1;
      C_OP_SW:   o_dec.i_sw   = 1'b1;
      C_OP_BEQ:  o_dec.i_beq  = 1'b1;
      C_OP_BNE:  o_dec.i_bne  = 1'b1;
      C_OP_LUI:  o_dec.i_lui  = 1'b1;
      C_OP_J:    o_dec.i_j    = 1'b1;
      C_OP_JAL:  o_dec.i_jal  = 1'b1;
      default:   o_illegal    = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_cu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mc_cu                                                                |
// | Multi-cycle control unit: IF/ID/EXE/MEM/WB sequencer and strobes.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mc_cu
  import mc_cu_pkg::*;
(
  input  wire logic clock,
  input  wire logic resetn,
  mc_cu_if.master   bus
);

  instr_t w_dec;
  logic   w_illegal;
  state_e r_state;
  state_e w_next;

  logic w_r_alu, w_shift_op, w_imm_op, w_jump, w_taken;

  logic       w_mem_req, w_iord, w_wmem, w_wir, w_wpc, w_wreg;
  logic       w_regrt, w_m2reg, w_jal, w_shift, w_alusrca, w_sext;
  logic [3:0] w_aluc;
  logic [1:0] w_alusrcb, w_pcsource;

  mc_cu_decode u_decode (
    .i_op      (bus.op),
    .i_func    (bus.func),
    .o_dec     (w_dec),
    .o_illegal (w_illegal)
  );

  assign w_r_alu    = w_dec.i_add | w_dec.i_sub | w_dec.i_and | w_dec.i_or | w_dec.i_xor;
  assign w_shift_op = w_dec.i_sll | w_dec.i_srl | w_dec.i_sra;
  assign w_imm_op   = w_dec.i_addi | w_dec.i_andi | w_dec.i_ori | w_dec.i_xori | w_dec.i_lui;
  assign w_jump     = w_dec.i_j | w_dec.i_jal | w_dec.i_jr;
  assign w_taken    = (w_dec.i_beq & bus.z) | (w_dec.i_bne & ~bus.z);

  always_ff @(posedge clock) begin
    if (!resetn) r_state <= S_IF;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:  w_next = bus.mem_ready ? S_ID : S_IF;
      S_ID:  w_next = (w_jump | w_illegal) ? S_IF : S_EXE;
      S_EXE: begin
        if (w_dec.i_lw | w_dec.i_sw)         w_next = S_MEM;
        else if (w_dec.i_beq | w_dec.i_bne)  w_next = S_IF;
        else if (w_r_alu | w_shift_op | w_imm_op) w_next = S_WB;
        else                                 w_next = S_IF;
      end
      S_MEM: begin
        if (!bus.mem_ready)   w_next = S_MEM;
        else if (w_dec.i_lw)  w_next = S_WB;
        else                  w_next = S_IF;
      end
      S_WB:  w_next = S_IF;
      default: w_next = S_IF;
    endcase
  end

  always_comb begin
    w_mem_req  = 1'b0;
    w_iord     = 1'b0;
    w_wmem     = 1'b0;
    w_wir      = 1'b0;
    w_wpc      = 1'b0;
    w_wreg     = 1'b0;
    w_regrt    = 1'b0;
    w_m2reg    = 1'b0;
    w_jal      = 1'b0;
    w_aluc     = C_ALU_ADD;
    w_shift    = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = C_SRCB_REGB;
    w_sext     = 1'b0;
    w_pcsource = C_PC_ALU;
    case (r_state)
      S_IF: begin
        w_mem_req = 1'b1;
        w_alusrca = 1'b1;
        w_alusrcb = C_SRCB_FOUR;
        w_wpc     = bus.mem_ready;
        w_wir     = bus.mem_ready;
      end
      S_ID: begin
        // ALUout captures the branch target while the register file is read.
        w_alusrca = 1'b1;
        w_alusrcb = C_SRCB_IMMSH;
        w_sext    = 1'b1;
        if (!w_illegal) begin
          if (w_dec.i_j | w_dec.i_jal) begin
            w_wpc      = 1'b1;
            w_pcsource = C_PC_JUMP;
          end
          if (w_dec.i_jal) begin
            w_wreg = 1'b1;
            w_jal  = 1'b1;
          end
          if (w_dec.i_jr) begin
            w_wpc      = 1'b1;
            w_pcsource = C_PC_REGA;
          end
        end
      end
      S_EXE: begin
        w_aluc  = alu_op(w_dec);
        w_shift = w_shift_op;
        w_sext  = w_dec.i_addi | w_dec.i_lw | w_dec.i_sw;
        if (w_imm_op | w_dec.i_lw | w_dec.i_sw) w_alusrcb = C_SRCB_IMM;
        if (w_taken) begin
          w_wpc      = 1'b1;
          w_pcsource = C_PC_ALUOUT;
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        w_wmem    = w_dec.i_sw;
      end
      S_WB: begin
        w_wreg  = 1'b1;
        w_m2reg = w_dec.i_lw;
        w_regrt = w_imm_op | w_dec.i_lw;
      end
      default: begin
      end
    endcase
  end

  // Strobes are gated by reset so an abandoned instruction never commits.
  assign bus.mem_req  = resetn & w_mem_req;
  assign bus.wmem     = resetn & w_wmem;
  assign bus.wir      = resetn & w_wir;
  assign bus.wpc      = resetn & w_wpc;
  assign bus.wreg     = resetn & w_wreg;
  assign bus.iord     = w_iord;
  assign bus.regrt    = w_regrt;
  assign bus.m2reg    = w_m2reg;
  assign bus.jal      = w_jal;
  assign bus.aluc     = w_aluc;
  assign bus.shift    = w_shift;
  assign bus.alusrca  = w_alusrca;
  assign bus.alusrcb  = w_alusrcb;
  assign bus.sext     = w_sext;
  assign bus.pcsource = w_pcsource;
  assign bus.state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_cu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mc_cu                                                             |
// | Directed table-driven bench for the multi-cycle control unit.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mc_cu;

  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SLL = 6'b000000, FN_JR = 6'b001000;

  // strobe order {mem_req, wmem, wir, wpc, wreg, jal}
  localparam logic [5:0] ST_0 = 6'b000000, ST_IF = 6'b101100, ST_IFW = 6'b100000;
  localparam logic [5:0] ST_WB = 6'b000010, ST_PC = 6'b000100, ST_JAL = 6'b000111;
  localparam logic [5:0] ST_MR = 6'b100000, ST_MW = 6'b110000;
  // select order {iord, alusrca, alusrcb, pcsource, aluc, shift, sext, regrt, m2reg}
  localparam logic [13:0] SEL_IF   = 14'b0_1_01_00_0000_0_0_0_0;
  localparam logic [13:0] SEL_ID   = 14'b0_1_11_00_0000_0_1_0_0;
  localparam logic [13:0] SEL_J    = 14'b0_1_11_11_0000_0_1_0_0;
  localparam logic [13:0] SEL_JR   = 14'b0_1_11_10_0000_0_1_0_0;
  localparam logic [13:0] SEL_0    = 14'b0_0_00_00_0000_0_0_0_0;
  localparam logic [13:0] SEL_ORI  = 14'b0_0_10_00_0101_0_0_0_0;
  localparam logic [13:0] SEL_RT   = 14'b0_0_00_00_0000_0_0_1_0;
  localparam logic [13:0] SEL_SLL  = 14'b0_0_00_00_0011_1_0_0_0;
  localparam logic [13:0] SEL_LSA  = 14'b0_0_10_00_0000_0_1_0_0;
  localparam logic [13:0] SEL_MEM  = 14'b1_0_00_00_0000_0_0_0_0;
  localparam logic [13:0] SEL_LWB  = 14'b0_0_00_00_0000_0_0_1_1;
  localparam logic [13:0] SEL_BT   = 14'b0_0_00_01_0100_0_0_0_0;
  localparam logic [13:0] SEL_BN   = 14'b0_0_00_00_0100_0_0_0_0;

  typedef struct {
    logic        rn;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [2:0]  st;
    logic [5:0]  strb;
    logic [13:0] sel;
  } vec_t;

  logic  clk;
  logic  resetn;
  int    n_pass;
  int    n_total;
  vec_t  tv[$];

  mc_cu_if bus();

  mc_cu dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic drive(input logic rn, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy);
    @(negedge clk);
    resetn        = rn;
    bus.op        = op;
    bus.func      = fn;
    bus.z         = z;
    bus.mem_ready = rdy;
    #1;
  endtask

  task automatic check_all(input string tag, input logic [2:0] st,
                           input logic [5:0] strb, input logic [13:0] sel);
    chk({tag, ".state"}, {13'd0, bus.state}, {13'd0, st});
    chk({tag, ".strb"}, {10'd0, bus.mem_req, bus.wmem, bus.wir, bus.wpc, bus.wreg, bus.jal},
        {10'd0, strb});
    chk({tag, ".sel"}, {2'd0, bus.iord, bus.alusrca, bus.alusrcb, bus.pcsource, bus.aluc,
                        bus.shift, bus.sext, bus.regrt, bus.m2reg}, {2'd0, sel});
  endtask

  task automatic add(input logic rn, input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic rdy, input logic [2:0] st, input logic [5:0] strb,
                     input logic [13:0] sel);
    vec_t v;
    v.rn = rn; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
    v.st = st; v.strb = strb; v.sel = sel;
    tv.push_back(v);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    resetn = 1'b0;
    bus.op = '0; bus.func = '0; bus.z = 1'b0; bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    // reset held: IF, strobes forced low
    add(0, OP_R, FN_ADD, 0, 1, 3'd0, ST_0, SEL_IF);
    // add
    add(1, OP_R, FN_ADD, 0, 1, 3'd0, ST_IF, SEL_IF);
    add(1, OP_R, FN_ADD, 0, 1, 3'd1, ST_0, SEL_ID);
    add(1, OP_R, FN_ADD, 0, 1, 3'd2, ST_0, SEL_0);
    add(1, OP_R, FN_ADD, 0, 1, 3'd4, ST_WB, SEL_0);
    // ori
    add(1, OP_ORI, 6'h15, 0, 1, 3'd0, ST_IF, SEL_IF);
    add(1, OP_ORI, 6'h15, 0, 1, 3'd1, ST_0, SEL_ID);
    add(1, OP_ORI, 6'h15, 0, 1, 3'd2, ST_0, SEL_ORI);
    add(1, OP_ORI, 6'h15, 0, 1, 3'd4, ST_WB, SEL_RT);
    // sll
    add(1, OP_R, FN_SLL, 0, 1, 3'd0, ST_IF, SEL_IF);
    add(1, OP_R, FN_SLL, 0, 1, 3'd1, ST_0, SEL_ID);
    add(1, OP_R, FN_SLL, 0, 1, 3'd2, ST_0, SEL_SLL);
    add(1, OP_R, FN_SLL, 0, 1, 3'd4, ST_WB, SEL_0);
    // addi
    add(1, OP_ADDI, 6'h00, 0, 1, 3'd0, ST_IF, SEL_IF);
    add(1, OP_ADDI, 6'h00, 0, 1, 3'd1, ST_0, SEL_ID);
    add(1, OP_ADDI, 6'h00, 0, 1, 3'd2, ST_0, SEL_LSA);
    add(1, OP_ADDI, 6'h00, 0, 1, 3'd4, ST_WB, SEL_RT);
    // lw with two wait cycles in MEM
    add(1, OP_LW, 6'h00, 0, 1, 3'd0, ST_IF, SEL_IF);
    add(1, OP_LW, 6'h00, 0, 1, 3'd1, ST_0, SEL_ID);
    add(1, OP_LW, 6'h00, 0, 1, 3'd2, ST_0, SEL_LSA);
    add(1, OP_LW, 6'h00, 0, 0, 3'd3, ST_MR, SEL_MEM);
    add(1, OP_LW, 6'h00, 0, 0, 3'd3, ST_MR, SEL_MEM);
    add(1, OP_LW, 6'h00, 0, 1, 3'd3, ST_MR, SEL_MEM);
    add(1, OP_LW, 6'h00, 0, 1, 3'd4, ST_WB, SEL_LWB);
    // beq taken / not taken, bne inverse
    add(1, OP_BEQ, 6'h00, 1, 1, 3'd0, ST_IF, SEL_IF);
    add(1, OP_BEQ, 6'h00, 1, 1, 3'd1, ST_0, SEL_ID);
    add(1, OP_BEQ, 6'h00, 1, 1, 3'd2, ST_PC, SEL_BT);
    add(1, OP_BEQ, 6'h00, 0, 1, 3'd0, ST_IF, SEL_IF);
    add(1, OP_BEQ, 6'h00, 0, 1, 3'd1, ST_0, SEL_ID);
    add(1, OP_BEQ, 6'h00, 0, 1, 3'd2, ST_0, SEL_BN);
    add(1, OP_BNE, 6'h00, 0, 1, 3'd0, ST_IF, SEL_IF);
    add(1, OP_BNE, 6'h00, 0, 1, 3'd1, ST_0, SEL_ID);
    add(1, OP_BNE, 6'h00, 0, 1, 3'd2, ST_PC, SEL_BT);
    add(1, OP_BNE, 6'h00, 1, 1, 3'd0, ST_IF, SEL_IF);
    add(1, OP_BNE, 6'h00, 1, 1, 3'd1, ST_0, SEL_ID);
    add(1, OP_BNE, 6'h00, 1, 1, 3'd2, ST_0, SEL_BN);
    // jal, j, jr: two cycles each
    add(1, OP_JAL, 6'h00, 0, 1, 3'd0, ST_IF, SEL_IF);
    add(1, OP_JAL, 6'h00, 0, 1, 3'd1, ST_JAL, SEL_J);
    add(1, OP_J, 6'h00, 0, 1, 3'd0, ST_IF, SEL_IF);
    add(1, OP_J, 6'h00, 0, 1, 3'd1, ST_PC, SEL_J);
    add(1, OP_R, FN_JR, 0, 1, 3'd0, ST_IF, SEL_IF);
    add(1, OP_R, FN_JR, 0, 1, 3'd1, ST_PC, SEL_JR);
    // undefined opcode, then IF stalls with mem_ready low
    add(1, OP_BAD, 6'h00, 0, 1, 3'd0, ST_IF, SEL_IF);
    add(1, OP_BAD, 6'h00, 0, 1, 3'd1, ST_0, SEL_ID);
    add(1, OP_BAD, 6'h00, 0, 0, 3'd0, ST_IFW, SEL_IF);
    add(1, OP_BAD, 6'h00, 0, 0, 3'd0, ST_IFW, SEL_IF);
    // reset asserted in EXE of a taken beq: no wpc, back to IF
    add(1, OP_BEQ, 6'h00, 1, 1, 3'd0, ST_IF, SEL_IF);
    add(1, OP_BEQ, 6'h00, 1, 1, 3'd1, ST_0, SEL_ID);
    add(0, OP_BEQ, 6'h00, 1, 1, 3'd2, ST_0, SEL_BT);
    add(1, OP_BEQ, 6'h00, 1, 1, 3'd0, ST_IF, SEL_IF);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rn, tv[i].op, tv[i].fn, tv[i].z, tv[i].rdy);
      check_all($sformatf("v%0d", i), tv[i].st, tv[i].strb, tv[i].sel);
    end

    // Finish the beq left in ID, then sw with three MEM wait cycles.
    drive(1, OP_BEQ, 6'h00, 0, 1);
    chk("beq_tail.state", {13'd0, bus.state}, 16'd1);
    drive(1, OP_BEQ, 6'h00, 0, 1);
    chk("beq_tail.exe", {13'd0, bus.state}, 16'd2);
    drive(1, OP_SW, 6'h00, 0, 1);
    chk("sw.if", {13'd0, bus.state}, 16'd0);
    drive(1, OP_SW, 6'h00, 0, 1);
    drive(1, OP_SW, 6'h00, 0, 1);
    chk("sw.exe.sext", {15'd0, bus.sext}, 16'd1);
    for (int k = 0; k < 4; k++) begin
      drive(1, OP_SW, 6'h00, 0, (k == 3) ? 1'b1 : 1'b0);
      chk($sformatf("sw.mem%0d.state", k), {13'd0, bus.state}, 16'd3);
      chk($sformatf("sw.mem%0d.wmem", k), {14'd0, bus.wmem, bus.wreg}, 16'b10);
    end
    drive(1, OP_R, FN_ADD, 0, 1);
    chk("sw.done.state", {13'd0, bus.state}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
